// File: rtl/mdu_pkg.sv
// Shared encodings and sizes for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_N = 32;
  localparam int unsigned CNT_W = $clog2(MDU_N);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_adder.sv
// Ripple-carry adder shared by the multiply and divide iterations.
module mul_div_unit_adder #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic carry;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    carry = cin_i;
    sum_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum_c[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_c = carry;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned N = MDU_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = 2 * N;
  localparam int unsigned AW = N + 1;

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           is_sgn_q, is_sgn_d;
  logic           neg_q, neg_d;
  logic           sa_q, sa_d;
  logic           bz_q, bz_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   mq_q, mq_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [AW-1:0]  add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  logic           start_sgn;
  logic [N-1:0]   a_mag, b_mag;
  logic [PW-1:0]  prod, prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  // Operand magnitudes for the start cycle; the most negative value stays as its unsigned pattern.
  always_comb begin
    start_sgn = ~op[0];
    a_mag     = (start_sgn && a[N-1]) ? (~a + N'(1)) : a;
    b_mag     = (start_sgn && b[N-1]) ? (~b + N'(1)) : b;
  end

  // Adder operand mux: accumulate for multiply, trial-subtract for divide.
  always_comb begin
    if (is_div_q) begin
      add_a   = {acc_q, mq_q[N-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q};
      add_b   = mq_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
  end

  mul_div_unit_adder #(
    .W (AW)
  ) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_c  (add_sum),
    .cout_c (add_cout)
  );

  // Sign fixup of the raw magnitudes, consumed in FIX.
  always_comb begin
    prod     = {acc_q, mq_q};
    prod_fix = (is_sgn_q && neg_q) ? (~prod + PW'(1)) : prod;
    quo_fix  = (is_sgn_q && neg_q) ? (~mq_q + N'(1)) : mq_q;
    rem_fix  = (is_sgn_q && sa_q) ? (~acc_q + N'(1)) : acc_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    bz_d     = bz_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          is_sgn_d = start_sgn;
          neg_d    = a[N-1] ^ b[N-1];
          sa_d     = a[N-1];
          bz_d     = (b == '0);
          acc_d    = '0;
          mq_d     = op[1] ? a_mag : b_mag;
          opnd_d   = op[1] ? b_mag : a_mag;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = add_cout ? add_sum[N-1:0] : {acc_q[N-2:0], mq_q[N-1]};
          mq_d  = {mq_q[N-2:0], add_cout};
        end else begin
          acc_d = add_sum[N:1];
          mq_d  = {add_sum[0], mq_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[PW-1:N];
          lo_d = prod_fix[N-1:0];
        end else if (bz_q) begin
          hi_d = acc_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      bz_q     <= 1'b0;
      acc_q    <= '0;
      mq_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      bz_q     <= bz_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO queued at start, checked on done.
module tb_mul_div_unit;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         hi_we, lo_we;
  logic [N-1:0] wdata;
  logic         busy, done;
  logic [N-1:0] hi, lo;

  int n_total;
  int n_bad;

  logic [63:0] sb_q[$];

  mul_div_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [31:0] mag;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        q = sx * sy;
        p = 64'(q);
      end
      2'b01: p = 64'(x) * 64'(y);
      2'b10: begin
        if (y == 32'd0) begin
          mag = x[31] ? (32'd0 - x) : x;
          p   = {mag, 32'hFFFF_FFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else            p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && done) begin
      check_eq("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("hi", 64'(hi), 64'(e[63:32]));
        check_eq("lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  // Start one op, then check latency and busy length up to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp);
    int cyc;
    int busy_cnt;
    bit got;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; op = 2'(~o);
    cyc = 0; busy_cnt = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      cyc++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else @(posedge clk);
    end
    check_eq("done_seen", 64'(got), 64'd1);
    check_eq("latency", 64'(cyc), 64'(N + 2));
    check_eq("busy_cycles", 64'(busy_cnt), 64'(N + 1));
    check_eq("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (k < budget && !done) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_in_budget", 64'(done), 64'd1);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'd7, 32'd6, {32'h0000_0000, 32'h0000_002A});
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_op(2'b11, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, {32'h0000_0100, 32'hFFFF_FFFF});

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : 32'($urandom);
      if (i == 6) rb = 32'($urandom_range(1, 9));
      run_op(ro, ra, rb, model(ro, ra, rb));
    end

    // MTHI/MTLO in idle, visible next cycle.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check_eq("mthi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check_eq("mtlo", 64'(lo), 64'h0000_0000_CAFE_F00D);
    check_eq("mthi_hold", 64'(hi), 64'h0000_0000_DEAD_BEEF);

    // Start and MTHI together in idle: the write is dropped.
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; hi_we = 1'b1; wdata = 32'h1111_2222;
    sb_q.push_back({32'd0, 32'd12});
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check_eq("start_wins_hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    wait_done(N + 4);
    @(negedge clk);

    // Restart and MTHI issued 10 cycles into an op are both ignored.
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    op = 2'b01; a = 32'd9; b = 32'd11; start = 1'b1;
    sb_q.push_back({32'd0, 32'd99});
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check_eq("busy_mid_op", 64'(busy), 64'd1);
    check_eq("busy_write_dropped", 64'(hi), 64'h0000_0000_A5A5_A5A5);
    wait_done(N + 4);
    repeat (N + 6) @(negedge clk);
    check_eq("no_second_op", 64'(busy), 64'd0);
    check_eq("hi_after_ignore", 64'(hi), 64'd0);
    check_eq("lo_after_ignore", 64'(lo), 64'd99);

    // Asynchronous reset mid-CALC clears everything at once.
    @(negedge clk);
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_hi", 64'(hi), 64'd0);
    check_eq("arst_lo", 64'(lo), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 32'd7, 32'd6, {32'h0000_0000, 32'h0000_002A});

    repeat (4) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
